wb_stage_reg: RTL

Parametrised successor to the combinational writeback mux. It registers the MEM/WB boundary and performs load-data alignment and sign/zero extension (LB/LH/LW/LBU/LHU). It selects among ALU, aligned load, PC+4 and immediate (LUI) sources, and supports stall, flush and valid tracking. It also keeps a retired-instruction counter. It sits between the memory stage and the register file / forwarding unit.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_stage_reg_load_align.sv | 40 ++++
 rtl/wb_stage_reg.sv | 92 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: source-select encoding,
// RV32 load funct3 codes and the poison word.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] POISON_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/wb_stage_reg_load_align.sv
// Combinational load-data aligner: picks the byte/halfword addressed by the low
// address bits and sign- or zero-extends it to XLEN.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] POISON = POISON_WORD
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] aligned
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
    endcase
    // addr_lo[0] is deliberately ignored for halfwords; misalignment is trapped upstream
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    aligned = POISON;
    case (funct3)
      F3_LB:   aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  aligned = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  aligned = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   aligned = mem_rdata;
      default: aligned = POISON;
    endcase
  end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register: load alignment, writeback source select, stall/flush
// handling, x0 protection and a retired-instruction counter.
module wb_stage_reg
  import wb_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     REG_ADDR_W = 5,
  parameter int unsigned     CNT_W      = 64,
  parameter logic [XLEN-1:0] POISON     = POISON_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc_plus_4,
  input  logic [XLEN-1:0]       imm,
  input  logic [1:0]            wb_sel,
  input  logic [2:0]            load_funct3,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  regwrite_in,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_regwen,
  output logic [CNT_W-1:0]      retire_count
);

  logic [XLEN-1:0] load_data_p0;
  logic [XLEN-1:0] sel_data_p0;
  logic            regwen_p0;
  wb_sel_e         sel_p0;

  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [XLEN-1:0]       data_p1;
  logic                  regwen_p1;
  logic [CNT_W-1:0]      cnt_p1;

  // Stage p0: combinational alignment and source select
  load_align #(
    .XLEN   (XLEN),
    .POISON (POISON)
  ) u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (alu_result[1:0]),
    .funct3    (load_funct3),
    .aligned   (load_data_p0)
  );

  assign sel_p0    = wb_sel_e'(wb_sel);
  assign regwen_p0 = in_valid & regwrite_in & (rd_in != '0);

  always_comb begin
    sel_data_p0 = alu_result;
    case (sel_p0)
      WB_ALU: sel_data_p0 = alu_result;
      WB_MEM: sel_data_p0 = load_data_p0;
      WB_PC4: sel_data_p0 = pc_plus_4;
      WB_IMM: sel_data_p0 = imm;
    endcase
  end

  // Stage p1: the WB register; priority rst > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      rd_p1     <= '0;
      data_p1   <= '0;
      regwen_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      regwen_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1    <= in_valid;
      rd_p1     <= rd_in;
      data_p1   <= sel_data_p0;
      regwen_p1 <= regwen_p0;
      cnt_p1    <= cnt_p1 + CNT_W'(in_valid);
    end
  end

  assign wb_valid     = vld_p1;
  assign wb_rd        = rd_p1;
  assign wb_data      = data_p1;
  assign wb_regwen    = regwen_p1;
  assign retire_count = cnt_p1;

endmodule
